uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter between NUM_REQ 16-bit result producers (CPU DataOut path, status/echo sources).
//  Round-robin grant; each accepted word is serialized as two bytes, MSB first, onto the UART TX strobe/data inputs.
//  Sits between the producers and UART_TOP's f_write/i_TxData pins; UART TX holds tx_busy high while shifting a byte.
// PARAMETERS
//  NUM_REQ  2  number of requesters, legal 1..4
// PORTS
//  clk        in   1           system clock, all logic on rising edge
//  reset      in   1           synchronous, active-high reset
//  req_valid  in   NUM_REQ     requester i holds a word to send
//  req_data   in   16*NUM_REQ  word of requester i in bits [16i+15:16i]
//  req_ready  out  NUM_REQ     one-hot accept pulse; word i taken when valid&ready
//  tx_busy    in   1           UART transmitter shifting a byte
//  tx_en      out  1           one-cycle byte write strobe to UART (f_write)
//  tx_data    out  8           byte presented with tx_en, held until next strobe
//  arb_busy   out  1           high from accept until last byte finished
// BEHAVIOUR
//  Reset: req_ready=0, tx_en=0, tx_data=8'h00, arb_busy=0, state=IDLE, rr_ptr=NUM_REQ-1 (req 0 wins first).
//  FSM: IDLE -> [TAG -> WAIT_TAG ->] SEND_HI -> WAIT_HI -> SEND_LO -> WAIT_LO -> IDLE.
//  IDLE: if any req_valid, grant first valid index searching rr_ptr+1, rr_ptr+2 ... modulo NUM_REQ;
//   req_ready[g]=1 for exactly that cycle, req_data[g] latched, rr_ptr<=g, arb_busy<=1 next cycle.
//  Requester must hold req_valid/req_data stable until its ready pulse; dropping valid before grant withdraws it.
//  SEND_x: entered only with tx_busy=0 (else stall); tx_en=1 one cycle, tx_data=byte (HI=[15:8], LO=[7:0]).
//  WAIT_x: wait for tx_busy=1 (byte started) then tx_busy=0 (byte done); then advance.
//  WAIT_LO done: arb_busy<=0, back to IDLE; new grant earliest next cycle (1 idle cycle between words).
//  Latency: valid (idle, UART free) -> ready same cycle -> first tx_en 1 cycle later.
//  Simultaneous valids: strict round-robin; a requester held valid is served within NUM_REQ words.
//  Valid arriving while arb_busy: ignored until IDLE, never lost if held.
//  tx_busy high on entry to SEND_x: stall in SEND_x with tx_en=0 until it falls.
//  No timeout: a UART that never asserts tx_busy hangs in WAIT_x (documented; UART_TOP guarantees it).
//  rr_ptr wraps NUM_REQ-1 -> 0; NUM_REQ=1 degenerates to fixed grant.
//  Reset mid-word: abandon word, all outputs to reset values next cycle; partial byte in UART not recalled.
//  req_ready never asserted outside IDLE; at most one bit set; tx_en never two consecutive cycles.
// CONFIGURATION
//  UART_TX_ARB_TAG_EN defined: each word preceded by tag byte {6'b101000, g[1:0]} via TAG/WAIT_TAG,
//   3 bytes per word, same strobe/wait rules; host demuxes by tag.
//  Undefined: TAG states removed, exactly 2 bytes per word, no tag logic synthesized.
// TESTING
//  Single req0 word 16'hA55A, tx_busy model 10 cycles/byte -> ready0 one pulse, tx_data A5 then 5A, arb_busy drops after 2nd byte.
//  req0,req1 both valid from reset with 16'h1111/16'h2222 -> order 11,11,22,22,11,11 ... alternating, no starvation.
//  tx_busy held high before first byte -> tx_en stays 0 until tx_busy low, then single strobe.
//  reset asserted in WAIT_HI -> next cycle tx_en=0, arb_busy=0, req_ready=0; next grant restarts at req0.
//  req1 valid mid-transfer of req0 word -> req1 granted only after WAIT_LO completes, 1 idle cycle gap.
//  With UART_TX_ARB_TAG_EN, req1 16'hBEEF -> bytes A1, BE, EF; without -> BE, EF only.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ 16-bit producers.
// Round-robin grant; each word goes out MSB byte first as tx_en strobes.
//
// Ports:
//   clk        rising-edge system clock
//   reset      synchronous, active-high reset
//   req_valid  per-requester "word pending"
//   req_data   word of requester i in [16i+15:16i]
//   req_ready  one-hot accept pulse (combinational, IDLE only)
//   tx_busy    UART is shifting a byte
//   tx_en      one-cycle byte write strobe to the UART
//   tx_data    byte presented with tx_en, held until the next strobe
//   arb_busy   high from accept until the last byte has finished
//
// Option: define UART_TX_ARB_TAG_EN to prefix every word with the tag
// byte {6'b101000, grant[1:0]} (3 bytes per word). Undefined: 2 bytes.

module uart_tx_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [16*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  tx_busy,
    output logic                  tx_en,
    output logic [7:0]            tx_data,
    output logic                  arb_busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEND_HI = 3'd1,
        S_WAIT_HI = 3'd2,
        S_SEND_LO = 3'd3,
        S_WAIT_LO = 3'd4
`ifdef UART_TX_ARB_TAG_EN
        ,
        S_TAG      = 3'd5,
        S_WAIT_TAG = 3'd6
`endif
    } state_t;

    state_t      state_q;
    logic [1:0]  rr_ptr_q;
    logic [15:0] word_q;
    logic        tx_en_q;
    logic [7:0]  tx_data_q;
    logic        arb_busy_q;
    // tx_busy has been seen high in the current WAIT state
    logic        seen_q;

    logic        grant_vld;
    logic [1:0]  grant_idx;
    logic [15:0] grant_word;
    logic [7:0]  first_byte;
    logic [7:0]  send_byte;

    // Search rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ; nearest valid wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_vld && req_valid[i] &&
                    ((int'(rr_ptr_q) + k) % NUM_REQ) == i) begin
                    grant_vld = 1'b1;
                    grant_idx = 2'(i);
                end
            end
        end
    end

    always_comb begin
        grant_word = 16'h0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == 2'(i)) begin
                grant_word = req_data[16*i +: 16];
            end
        end
    end

    // Accept pulse is combinational so the word is taken in the same cycle.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = !reset && (state_q == S_IDLE) &&
                           grant_vld && (grant_idx == 2'(i));
        end
    end

`ifdef UART_TX_ARB_TAG_EN
    assign first_byte = {6'b101000, grant_idx};
`else
    assign first_byte = grant_word[15:8];
`endif

    // Byte to present when a SEND state retries after a stall.
    always_comb begin
        send_byte = tx_data_q;
        unique case (state_q)
            S_SEND_HI: send_byte = word_q[15:8];
            S_SEND_LO: send_byte = word_q[7:0];
`ifdef UART_TX_ARB_TAG_EN
            S_TAG:     send_byte = {6'b101000, rr_ptr_q};
`endif
            default:   send_byte = tx_data_q;
        endcase
    end

    // SEND states: the strobe is raised on entry when the UART is free,
    // otherwise the state stalls with tx_en low until tx_busy falls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= 2'(NUM_REQ - 1);
            word_q     <= 16'h0000;
            tx_en_q    <= 1'b0;
            tx_data_q  <= 8'h00;
            arb_busy_q <= 1'b0;
            seen_q     <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (grant_vld) begin
                        rr_ptr_q   <= grant_idx;
                        word_q     <= grant_word;
                        arb_busy_q <= 1'b1;
                        seen_q     <= 1'b0;
`ifdef UART_TX_ARB_TAG_EN
                        state_q    <= S_TAG;
`else
                        state_q    <= S_SEND_HI;
`endif
                        if (!tx_busy) begin
                            tx_en_q   <= 1'b1;
                            tx_data_q <= first_byte;
                        end
                    end
                end
`ifdef UART_TX_ARB_TAG_EN
                S_TAG: begin
                    if (tx_en_q) begin
                        tx_en_q <= 1'b0;
                        state_q <= S_WAIT_TAG;
                    end else if (!tx_busy) begin
                        tx_en_q   <= 1'b1;
                        tx_data_q <= send_byte;
                    end
                end
                S_WAIT_TAG: begin
                    if (tx_busy) begin
                        seen_q <= 1'b1;
                    end else if (seen_q) begin
                        seen_q    <= 1'b0;
                        state_q   <= S_SEND_HI;
                        tx_en_q   <= 1'b1;
                        tx_data_q <= word_q[15:8];
                    end
                end
`endif
                S_SEND_HI: begin
                    if (tx_en_q) begin
                        tx_en_q <= 1'b0;
                        state_q <= S_WAIT_HI;
                    end else if (!tx_busy) begin
                        tx_en_q   <= 1'b1;
                        tx_data_q <= send_byte;
                    end
                end
                S_WAIT_HI: begin
                    if (tx_busy) begin
                        seen_q <= 1'b1;
                    end else if (seen_q) begin
                        seen_q    <= 1'b0;
                        state_q   <= S_SEND_LO;
                        tx_en_q   <= 1'b1;
                        tx_data_q <= word_q[7:0];
                    end
                end
                S_SEND_LO: begin
                    if (tx_en_q) begin
                        tx_en_q <= 1'b0;
                        state_q <= S_WAIT_LO;
                    end else if (!tx_busy) begin
                        tx_en_q   <= 1'b1;
                        tx_data_q <= send_byte;
                    end
                end
                S_WAIT_LO: begin
                    if (tx_busy) begin
                        seen_q <= 1'b1;
                    end else if (seen_q) begin
                        seen_q     <= 1'b0;
                        state_q    <= S_IDLE;
                        arb_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_en    = tx_en_q;
    assign tx_data  = tx_data_q;
    assign arb_busy = arb_busy_q;

endmodule
